fetch_queue_unit: RTL and testbench

Parametrised instruction-fetch stage with a decoupling fetch queue between the synchronous instruction memory and decode. It generates sequential PCs, accepts branch/jump redirects, and tracks one-cycle-latency memory responses. It buffers up to FQ_DEPTH instructions with their PC and PC+4, and presents them to decode through a valid/ready handshake. It adds backpressure, flush and in-flight discard, which the single-register fetch stage lacks.

---
 rtl/fetch_queue_unit.sv | 107 ++++++++++
 tb/tb_fetch_queue_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: sequential PC generation, one-cycle memory response tracking,
// and a small fetch queue presenting {instr, pc, pc+4} to decode over valid/ready.
module fetch_queue_unit #(
    parameter int              XLEN     = 32,
    parameter int              IMEM_AW  = 11,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              FQ_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        redirect_valid,
    input  logic [XLEN-1:0]             redirect_pc,
    output logic [IMEM_AW-1:0]          imem_addr,
    output logic                        imem_rden,
    input  logic [31:0]                 imem_rdata,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 out_instr,
    output logic [XLEN-1:0]             out_pc,
    output logic [XLEN-1:0]             out_npc,
    output logic [$clog2(FQ_DEPTH):0]   fq_count
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;

    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

    logic [XLEN-1:0] fetch_pc_p0;
    logic [XLEN-1:0] req_pc_p1;
    logic            vld_p1;
    logic [CW-1:0]   count;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW:0]     occupancy;
    logic            issue;
    logic            push;
    logic            pop;

    logic [31:0]     q_instr [FQ_DEPTH];
    logic [XLEN-1:0] q_pc    [FQ_DEPTH];
    logic [XLEN-1:0] q_npc   [FQ_DEPTH];

    // Queued entries plus the outstanding request must never exceed the queue depth,
    // so every response that comes back has a free slot.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, vld_p1};
    assign issue     = !rst && !redirect_valid && (occupancy < (CW+1)'(FQ_DEPTH));
    assign push      = vld_p1 && !redirect_valid;
    assign pop       = out_valid && out_ready && !redirect_valid;

    assign imem_rden = issue;
    assign imem_addr = fetch_pc_p0[IMEM_AW+1:2];

    // Stage p0 -> p1: PC generation, request tracking and queue bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_p0 <= RESET_PC;
            vld_p1      <= 1'b0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redirect_valid) begin
            fetch_pc_p0 <= redirect_pc & ~XLEN'(3);
            vld_p1      <= 1'b0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            vld_p1 <= issue;
            if (issue)
                fetch_pc_p0 <= pc_plus4(fetch_pc_p0);
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (issue)
            req_pc_p1 <= fetch_pc_p0;
    end

    // Stage p1 -> p2: response capture into the queue
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]    <= req_pc_p1;
            q_npc[wr_ptr]   <= pc_plus4(req_pc_p1);
        end
    end

    // Stage p2: head of queue to decode; zeroed when empty so reset shows all-zero outputs
    assign fq_count  = count;
    assign out_valid = (count != '0);
    assign out_instr = out_valid ? q_instr[rd_ptr] : '0;
    assign out_pc    = out_valid ? q_pc[rd_ptr]    : '0;
    assign out_npc   = out_valid ? q_npc[rd_ptr]   : '0;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed phases push expected heads into scoreboards,
// negedge monitors pop and compare every accepted head.
module tb_fetch_queue_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] npc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [10:0] imem_addr;
    logic        imem_rden;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_npc;
    logic [2:0]  fq_count;

    logic        rst2;
    logic        redirect2 = 1'b0;
    logic [31:0] redirect_pc2 = 32'h0;
    logic [10:0] imem_addr2;
    logic        imem_rden2;
    logic [31:0] imem_rdata2;
    logic        out_valid2;
    logic        out_ready2;
    logic [31:0] out_instr2;
    logic [31:0] out_pc2;
    logic [31:0] out_npc2;
    logic [2:0]  fq_count2;

    int checks   = 0;
    int failures = 0;
    int deliv1   = 0;
    int deliv2   = 0;
    exp_t q1[$];
    exp_t q2[$];
    exp_t e1;
    exp_t e2;

    always #5 clk = ~clk;

    fetch_queue_unit #(.XLEN(32), .IMEM_AW(11), .RESET_PC(32'h0), .FQ_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_rden(imem_rden), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_npc(out_npc), .fq_count(fq_count)
    );

    fetch_queue_unit #(.XLEN(32), .IMEM_AW(11), .RESET_PC(32'hFFFF_FFF8), .FQ_DEPTH(4)) dut2 (
        .clk(clk), .rst(rst2), .redirect_valid(redirect2), .redirect_pc(redirect_pc2),
        .imem_addr(imem_addr2), .imem_rden(imem_rden2), .imem_rdata(imem_rdata2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_instr(out_instr2),
        .out_pc(out_pc2), .out_npc(out_npc2), .fq_count(fq_count2)
    );

    // Synchronous instruction memories: word at address a holds 0x1000 + a
    always @(posedge clk) begin
        if (imem_rden)
            imem_rdata <= 32'h1000 + {21'h0, imem_addr};
        if (imem_rden2)
            imem_rdata2 <= 32'h1000 + {21'h0, imem_addr2};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chk_head(input string name, input exp_t e,
                            input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] npc);
        checks++;
        if (pc !== e.pc || instr !== e.instr || npc !== e.npc) begin
            failures++;
            $display("FAIL %s actual pc=%h instr=%h npc=%h required pc=%h instr=%h npc=%h",
                     name, pc, instr, npc, e.pc, e.instr, e.npc);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] npc);
        exp_t e;
        e.pc = pc; e.instr = instr; e.npc = npc;
        q1.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitors: every accepted head must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            deliv1++;
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut1_unexpected actual pc=%h required none", out_pc);
            end else begin
                e1 = q1.pop_front();
                chk_head("dut1_head", e1, out_pc, out_instr, out_npc);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst2 && out_valid2 && out_ready2) begin
            deliv2++;
            if (q2.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut2_unexpected actual pc=%h required none", out_pc2);
            end else begin
                e2 = q2.pop_front();
                chk_head("dut2_head", e2, out_pc2, out_instr2, out_npc2);
            end
        end
    end

    initial begin
        exp_t w;
        rst = 1'b1; rst2 = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        out_ready = 1'b1; out_ready2 = 1'b0;
        tick; tick;

        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_fq_count", {29'h0, fq_count}, 32'h0);
        chk("rst_imem_rden", {31'h0, imem_rden}, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_npc", out_npc, 32'h0);
        chk("rst2_imem_rden", {31'h0, imem_rden2}, 32'h0);

        // Streaming from reset: three heads delivered, then stall
        push_exp(32'h00, 32'h1000, 32'h04); push_exp(32'h04, 32'h1001, 32'h08);
        push_exp(32'h08, 32'h1002, 32'h0C); push_exp(32'h0C, 32'h1003, 32'h10);
        push_exp(32'h10, 32'h1004, 32'h14); push_exp(32'h14, 32'h1005, 32'h18);
        push_exp(32'h18, 32'h1006, 32'h1C); push_exp(32'h1C, 32'h1007, 32'h20);
        rst = 1'b0;
        #1;
        chk("first_rden", {31'h0, imem_rden}, 32'h1);
        chk("first_addr", {21'h0, imem_addr}, 32'h0);
        tick;
        chk("latency_edge1_valid", {31'h0, out_valid}, 32'h0);
        tick;
        chk("latency_edge2_valid", {31'h0, out_valid}, 32'h1);
        tick; tick; tick;
        out_ready = 1'b0;
        chk("stream_delivered", deliv1, 3);

        // Backpressure: credit stops issue once count+inflight reaches depth
        tick; tick;
        chk("bp_count3", {29'h0, fq_count}, 32'h3);
        chk("bp_rden_credit", {31'h0, imem_rden}, 32'h0);
        repeat (8) tick;
        chk("bp_count_full", {29'h0, fq_count}, 32'h4);
        chk("bp_rden_full", {31'h0, imem_rden}, 32'h0);
        chk("bp_head_pc", out_pc, 32'h0C);
        out_ready = 1'b1;
        repeat (5) tick;
        chk("bp_delivered", deliv1, 8);
        chk("bp_sb_drained", q1.size(), 0);
        out_ready = 1'b0;

        // Redirect with three queued and one in flight
        tick;
        chk("pre_redirect_count", {29'h0, fq_count}, 32'h3);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        #1;
        chk("redirect_rden", {31'h0, imem_rden}, 32'h0);
        tick;
        redirect_valid = 1'b0;
        chk("flush_valid", {31'h0, out_valid}, 32'h0);
        chk("flush_count", {29'h0, fq_count}, 32'h0);
        push_exp(32'h200, 32'h1080, 32'h204);
        out_ready = 1'b1;
        tick;
        chk("redir_edge1_valid", {31'h0, out_valid}, 32'h0);
        tick;
        chk("redir_head_valid", {31'h0, out_valid}, 32'h1);
        chk("redir_head_pc", out_pc, 32'h200);
        chk("redir_head_npc", out_npc, 32'h204);

        // Unaligned redirect together with a pop of the current head
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        tick;
        redirect_valid = 1'b0;
        chk("pop_redirect_delivered", deliv1, 9);
        chk("pop_redirect_sb", q1.size(), 0);
        chk("align_imem_addr", {21'h0, imem_addr}, 32'h40);
        chk("align_count", {29'h0, fq_count}, 32'h0);
        push_exp(32'h100, 32'h1040, 32'h104);
        push_exp(32'h104, 32'h1041, 32'h108);
        push_exp(32'h108, 32'h1042, 32'h10C);
        repeat (5) tick;
        out_ready = 1'b0;
        chk("align_delivered", deliv1, 12);

        // Asynchronous reset mid-cycle with a full queue
        repeat (6) tick;
        chk("pre_rst_full", {29'h0, fq_count}, 32'h4);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'h0, out_valid}, 32'h0);
        chk("async_rst_count", {29'h0, fq_count}, 32'h0);
        chk("async_rst_rden", {31'h0, imem_rden}, 32'h0);
        #1 rst = 1'b0;
        chk("async_rst_sb", q1.size(), 0);
        push_exp(32'h00, 32'h1000, 32'h04);
        push_exp(32'h04, 32'h1001, 32'h08);
        out_ready = 1'b1;
        tick;
        chk("restart_edge1_valid", {31'h0, out_valid}, 32'h0);
        tick;
        chk("restart_edge2_valid", {31'h0, out_valid}, 32'h1);
        chk("restart_pc", out_pc, 32'h0);
        tick; tick;
        out_ready = 1'b0;
        chk("restart_delivered", deliv1, 14);

        // PC wrap-around near the top of the address space
        w.pc = 32'hFFFF_FFF8; w.instr = 32'h17FE; w.npc = 32'hFFFF_FFFC; q2.push_back(w);
        w.pc = 32'hFFFF_FFFC; w.instr = 32'h17FF; w.npc = 32'h0000_0000; q2.push_back(w);
        w.pc = 32'h0000_0000; w.instr = 32'h1000; w.npc = 32'h0000_0004; q2.push_back(w);
        rst2 = 1'b0;
        out_ready2 = 1'b1;
        #1;
        chk("wrap_first_addr", {21'h0, imem_addr2}, 32'h7FE);
        tick; tick;
        chk("wrap_head_pc", out_pc2, 32'hFFFF_FFF8);
        tick; tick; tick;
        out_ready2 = 1'b0;
        chk("wrap_delivered", deliv2, 3);
        chk("wrap_sb_drained", q2.size(), 0);

        tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
